tdm_fir_filt: RTL

Parametrised, multi-channel FIR filter that replaces the fixed single-channel sine filter. It uses one time-shared multiplier-accumulator over NUM_TAPS cycles per sample. Samples are 1s17, and per-channel delay lines are held internally. Coefficients are shared by all channels and loaded at runtime through a write port. The block has a valid/ready input handshake and a one-cycle output strobe, and sits between the sample source and downstream decimation/monitoring.

---
 rtl/fir_pkg.sv | 44 ++++
 rtl/fir_tap_mem.sv | 40 ++++
 rtl/tdm_fir_filt.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types, default widths and the output rounding/saturation helper
// for the time-division multiplexed FIR filter.
package fir_pkg;

  localparam int DEF_DATA_W    = 18;
  localparam int DEF_COEF_W    = 18;
  localparam int DEF_NUM_TAPS  = 17;
  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_OUT_SHIFT = 17;

  localparam int CH_W  = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;
  localparam int TAP_W = $clog2(DEF_NUM_TAPS);
  localparam int ACC_W = DEF_DATA_W + DEF_COEF_W + $clog2(DEF_NUM_TAPS);

  // Wide working width so round_sat serves any accumulator up to 64 bits.
  localparam int RS_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Round half up, then clamp to a signed data_w-bit range.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     shift,
    input int                     data_w
  );
    logic signed [RS_W-1:0] half;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    half = '0;
    if (shift > 0) half = 64'sd1 <<< (shift - 1);
    r  = (acc + half) >>> shift;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_tap_mem.sv
// Per-channel delay lines: a write shifts one channel's line by one tap,
// reads are combinational by channel and tap index.
module fir_tap_mem #(
  parameter int DATA_W   = 18,
  parameter int NUM_TAPS = 17,
  parameter int NUM_CH   = 2,
  parameter int CHW      = 1,
  parameter int TAPW     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_en,
  input  logic [CHW-1:0]           wr_ch,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [CHW-1:0]           rd_ch,
  input  logic [TAPW-1:0]          rd_tap,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [NUM_CH][NUM_TAPS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_TAPS; k++)
          mem[c][k] <= '0;
    end else if (shift_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch == CHW'(c)) begin
          mem[c][0] <= wr_data;
          for (int k = 1; k < NUM_TAPS; k++)
            mem[c][k] <= mem[c][k-1];
        end
      end
    end
  end

  assign rd_data = mem[rd_ch][rd_tap];

endmodule

// File: rtl/tdm_fir_filt.sv
// Multi-channel FIR with one shared multiply-accumulate stepped over the taps,
// runtime-loadable shared coefficients and a valid/ready sample input.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a sample; coefficient writes accepted
// ST_MAC  | one tap per cycle: acc += h[k] * x[ch][k]
// ST_OUT  | round/saturate acc into y, pulse out_valid, back to idle
module tdm_fir_filt
  import fir_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int COEF_W    = DEF_COEF_W,
  parameter  int NUM_TAPS  = DEF_NUM_TAPS,
  parameter  int NUM_CH    = DEF_NUM_CH,
  parameter  int OUT_SHIFT = DEF_OUT_SHIFT,
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TAPW      = $clog2(NUM_TAPS),
  localparam int ACCW      = DATA_W + COEF_W + $clog2(NUM_TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHW-1:0]           in_ch,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     coef_we,
  input  logic [TAPW-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic [CHW-1:0]           out_ch,
  output logic signed [DATA_W-1:0] y
);

  state_t                          state;
  logic [CHW-1:0]                  ch_q;
  logic [TAPW-1:0]                 k_q;
  logic signed [ACCW-1:0]          acc_q;
  logic signed [COEF_W-1:0]        coef [NUM_TAPS];
  logic signed [DATA_W-1:0]        tap_x;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACCW-1:0]          prod_ext;
  logic                            accept;
  logic                            ch_ok;
  logic                            addr_ok;
  logic                            last_tap;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign ch_ok    = (32'(in_ch) < NUM_CH);
  assign addr_ok  = (32'(coef_addr) < NUM_TAPS);
  assign last_tap = (k_q == TAPW'(NUM_TAPS - 1));

  assign prod     = coef[k_q] * tap_x;
  assign prod_ext = ACCW'(prod);

  fir_tap_mem #(
    .DATA_W   (DATA_W),
    .NUM_TAPS (NUM_TAPS),
    .NUM_CH   (NUM_CH),
    .CHW      (CHW),
    .TAPW     (TAPW)
  ) u_tap_mem (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept && ch_ok),
    .wr_ch    (in_ch),
    .wr_data  (x_in),
    .rd_ch    (ch_q),
    .rd_tap   (k_q),
    .rd_data  (tap_x)
  );

  // Writes only land while idle, so a MAC in flight always sees one coefficient set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_TAPS; k++)
        coef[k] <= '0;
    end else if (coef_we && in_ready && addr_ok) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ch_q      <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      y         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && ch_ok) begin
            ch_q  <= in_ch;
            k_q   <= '0;
            acc_q <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + prod_ext;
          k_q   <= k_q + TAPW'(1);
          if (last_tap) state <= ST_OUT;
        end
        ST_OUT: begin
          y         <= DATA_W'(round_sat(RS_W'(acc_q), OUT_SHIFT, DATA_W));
          out_ch    <= ch_q;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
